// File: rtl/ctx_fifo_reader.sv
// ctx_fifo_reader: drains a multi-context show-ahead FIFO round-robin into a 2-entry stream buffer.
// Optional build macro CTX_FIFO_READER_PRIO0_EN gives context 0 strict priority over the others.
module ctx_fifo_reader #(
  parameter int WIDTH   = 16,
  parameter int LOG_CTX = 3
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [(1<<LOG_CTX)*WIDTH-1:0]    fifo_data_out,
  input  logic [(1<<LOG_CTX)-1:0]          fifo_empty,
  input  logic                             fifo_error,
  output logic [LOG_CTX-1:0]               rcc_id,
  output logic                             read,
  input  logic [(1<<LOG_CTX)-1:0]          ctx_mask,
  input  logic                             halt,
  output logic                             halted,
  output logic [WIDTH-1:0]                 out_data,
  output logic [LOG_CTX-1:0]               out_ctx,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             error
);

  localparam int NUM_CTX = 1 << LOG_CTX;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALTING,
    ST_HALTED
  } state_t;

  state_t                       state_q, state_d;
  logic [LOG_CTX-1:0]           last_grant_q, last_grant_d;
  logic [1:0]                   count_q, count_d;
  logic [1:0][WIDTH-1:0]        data_q, data_d;
  logic [1:0][LOG_CTX-1:0]      ctx_q, ctx_d;
  logic                         error_q, error_d;

  logic [NUM_CTX-1:0]           eligible;
  logic                         grant_found;
  logic [LOG_CTX-1:0]           grant_idx;
  logic [WIDTH-1:0]             head_word;
  logic                         pop;
  logic                         room;

  assign eligible  = ~fifo_empty & ctx_mask;
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign room      = (count_q < 2'd2) || pop;
  assign out_data  = data_q[0];
  assign out_ctx   = ctx_q[0];
  assign halted    = (state_q == ST_HALTED);
  assign error     = error_q;

  // Search starts one past the last grant and ends on it, so a lone eligible context still wins.
  always_comb begin : p_grant
    logic [LOG_CTX-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
`ifdef CTX_FIFO_READER_PRIO0_EN
    if (eligible[0]) begin
      grant_found = 1'b1;
      grant_idx   = '0;
    end
`endif
    for (int i = 1; i <= NUM_CTX; i++) begin
      cand = last_grant_q + LOG_CTX'(i);
`ifdef CTX_FIFO_READER_PRIO0_EN
      if (!grant_found && (cand != '0) && eligible[cand]) begin
`else
      if (!grant_found && eligible[cand]) begin
`endif
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign read   = !reset && (state_q == ST_RUN) && grant_found && room;
  assign rcc_id = read ? grant_idx : '0;

  always_comb begin
    head_word = '0;
    for (int c = 0; c < NUM_CTX; c++) begin
      if (grant_idx == LOG_CTX'(c)) head_word = fifo_data_out[c*WIDTH +: WIDTH];
    end
  end

  // Entry 0 is always the oldest; a push lands behind whatever survives this cycle's pop.
  always_comb begin : p_buffer
    logic wr_slot;
    data_d  = data_q;
    ctx_d   = ctx_q;
    wr_slot = 1'b0;
    if (pop) begin
      data_d[0] = data_q[1];
      ctx_d[0]  = ctx_q[1];
    end
    if (read) begin
      wr_slot         = (count_q == 2'd2) || ((count_q == 2'd1) && !pop);
      data_d[wr_slot] = head_word;
      ctx_d[wr_slot]  = grant_idx;
    end
    count_d = count_q + {1'b0, read} - {1'b0, pop};
  end

  assign last_grant_d = read ? grant_idx : last_grant_q;
  assign error_d      = error_q | fifo_error | (read & fifo_empty[rcc_id]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (halt) state_d = ST_HALTING;
      ST_HALTING: begin
        if (!halt)                 state_d = ST_RUN;
        else if (count_q == 2'd0)  state_d = ST_HALTED;
      end
      ST_HALTED:  if (!halt) state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      last_grant_q <= LOG_CTX'(NUM_CTX - 1);
      count_q      <= 2'd0;
      data_q       <= '0;
      ctx_q        <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
      data_q       <= data_d;
      ctx_q        <= ctx_d;
      error_q      <= error_d;
    end
  end

endmodule

// File: tb/tb_ctx_fifo_reader.sv
// Bench for ctx_fifo_reader: queue-based FIFO and stream model checked every cycle, plus directed scenarios.
module tb_ctx_fifo_reader;
  localparam int W  = 16;
  localparam int LC = 3;
  localparam int N  = 8;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N*W-1:0]  fifo_data_out;
  logic [N-1:0]    fifo_empty;
  logic            fifo_error;
  logic [LC-1:0]   rcc_id;
  logic            read;
  logic [N-1:0]    ctx_mask;
  logic            halt;
  logic            halted;
  logic [W-1:0]    out_data;
  logic [LC-1:0]   out_ctx;
  logic            out_valid;
  logic            out_ready;
  logic            error;

  ctx_fifo_reader #(.WIDTH(W), .LOG_CTX(LC)) dut (
    .clock(clock), .reset(reset), .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
    .fifo_error(fifo_error), .rcc_id(rcc_id), .read(read), .ctx_mask(ctx_mask), .halt(halt),
    .halted(halted), .out_data(out_data), .out_ctx(out_ctx), .out_valid(out_valid),
    .out_ready(out_ready), .error(error)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int seq    = 0;

  logic [W-1:0] fq[N][$];
  int mq_d[$];
  int mq_c[$];
  int mlast;
  int mstate;
  bit merr;
  int exp_read;
  int exp_c;

  int grant_log[$];
  int grant_cyc[$];
  int xfer_data[$];
  int xfer_ctx[$];
  int xfer_cyc[$];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int rr_pick(logic [N-1:0] elig);
`ifdef CTX_FIFO_READER_PRIO0_EN
    if (elig[0]) return 0;
    for (int k = 1; k <= N; k++) begin
      int c = (mlast + k) % N;
      if (c != 0 && elig[c]) return c;
    end
`else
    for (int k = 1; k <= N; k++) begin
      int c = (mlast + k) % N;
      if (elig[c]) return c;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    mq_d.delete();
    mq_c.delete();
    mlast  = N - 1;
    mstate = 0;
    merr   = 1'b0;
  endtask

  task automatic clear_logs();
    grant_log.delete(); grant_cyc.delete();
    xfer_data.delete(); xfer_ctx.delete(); xfer_cyc.delete();
  endtask

  task automatic clear_fifos();
    for (int c = 0; c < N; c++) fq[c].delete();
  endtask

  // One clock: present FIFO heads, compare against the model, then advance model on the edge.
  task automatic step();
    logic [N-1:0] elig;
    for (int c = 0; c < N; c++) begin
      fifo_empty[c]         = (fq[c].size() == 0);
      fifo_data_out[c*W +: W] = (fq[c].size() != 0) ? fq[c][0] : 16'hDEAD;
    end
    #1;
    if (reset) model_reset();
    elig = ~fifo_empty & ctx_mask;
    if (reset) begin
      exp_read = 0;
      exp_c    = 0;
    end else begin
      exp_c    = rr_pick(elig);
      exp_read = (mstate == 0 && exp_c >= 0 &&
                  (mq_d.size() < 2 || (mq_d.size() == 2 && out_ready))) ? 1 : 0;
      if (exp_read == 0) exp_c = 0;
    end
    chk("read", int'(read), exp_read);
    chk("rcc_id", int'(rcc_id), exp_c);
    chk("out_valid", int'(out_valid), int'(mq_d.size() != 0));
    if (mq_d.size() != 0) begin
      chk("out_data", int'(out_data), mq_d[0]);
      chk("out_ctx", int'(out_ctx), mq_c[0]);
    end
    chk("halted", int'(halted), int'(mstate == 2));
    chk("error", int'(error), int'(merr));
    if (read) begin
      grant_log.push_back(int'(rcc_id));
      grant_cyc.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      xfer_data.push_back(int'(out_data));
      xfer_ctx.push_back(int'(out_ctx));
      xfer_cyc.push_back(cyc);
    end
    @(posedge clock);
    if (!reset) begin
      int sz = mq_d.size();
      if (fifo_error) merr = 1'b1;
      if (sz > 0 && out_ready) begin
        void'(mq_d.pop_front());
        void'(mq_c.pop_front());
      end
      if (exp_read != 0) begin
        mq_d.push_back(int'(fq[exp_c][0]));
        mq_c.push_back(exp_c);
        void'(fq[exp_c].pop_front());
        mlast = exp_c;
      end
      case (mstate)
        0: if (halt) mstate = 1;
        1: if (!halt) mstate = 0; else if (sz == 0) mstate = 2;
        2: if (!halt) mstate = 0;
        default: mstate = 0;
      endcase
    end
    cyc++;
    @(negedge clock);
  endtask

  task automatic do_reset();
    ctx_mask = '1; out_ready = 1'b1; halt = 1'b0; fifo_error = 1'b0;
    reset = 1'b1;
    step();
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_ctx", int'(out_ctx), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_read", int'(read), 0);
    step();
    reset = 1'b0;
    clear_logs();
  endtask

  initial begin
    int e1[3] = '{0, 2, 5};
    int e3[5] = '{4, 5, 6, 7, 4};
`ifdef CTX_FIFO_READER_PRIO0_EN
    int e6[5] = '{0, 0, 0, 3, 3};
`else
    int e6[5] = '{0, 3, 0, 3, 0};
`endif
    fifo_data_out = '0; fifo_empty = '1; fifo_error = 1'b0;
    ctx_mask = '1; halt = 1'b0; out_ready = 1'b1;
    model_reset();
    @(negedge clock);

    // Heads 0,2,5 drain on consecutive cycles
    clear_fifos();
    do_reset();
    fq[0].push_back(16'h0000); fq[2].push_back(16'h0002); fq[5].push_back(16'h0005);
    repeat (6) step();
    chk("t1_reads", grant_log.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < grant_log.size()) begin
        chk("t1_grant", grant_log[i], e1[i]);
        chk("t1_consec", grant_cyc[i] - grant_cyc[0], i);
      end
      if (i < xfer_ctx.size() && i < grant_cyc.size()) begin
        chk("t1_out_ctx", xfer_ctx[i], e1[i]);
        chk("t1_latency", xfer_cyc[i] - grant_cyc[i], 1);
      end
    end

    // Backpressure: buffer fills with 2, head held, then remainder streams without gaps
    clear_fifos();
    do_reset();
    for (int i = 0; i < 8; i++) fq[1].push_back(16'h0100 + 16'(i));
    out_ready = 1'b0;
    repeat (5) step();
    chk("t2_reads_held", grant_log.size(), 2);
    chk("t2_held_data", int'(out_data), 16'h0100);
    clear_logs();
    out_ready = 1'b1;
    repeat (10) step();
    chk("t2_reads_rest", grant_log.size(), 6);
    chk("t2_xfers", xfer_data.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < xfer_data.size()) begin
        chk("t2_order", xfer_data[i], 16'h0100 + i);
        chk("t2_nogap", xfer_cyc[i] - xfer_cyc[0], i);
      end
    end

    // Mask keeps only contexts 4..7
    clear_fifos();
    do_reset();
    for (int c = 0; c < N; c++) begin
      fq[c].push_back(16'(c * 16)); fq[c].push_back(16'(c * 16 + 1));
    end
    ctx_mask = 8'b1111_0000;
    repeat (10) step();
    chk("t3_reads", grant_log.size(), 8);
    for (int i = 0; i < 5; i++) if (i < grant_log.size()) chk("t3_grant", grant_log[i], e3[i]);

    // Halt with a full buffer
    clear_fifos();
    do_reset();
    for (int i = 0; i < 6; i++) fq[3].push_back(16'h0300 + 16'(i));
    out_ready = 1'b0;
    repeat (3) step();
    chk("t4_filled", grant_log.size(), 2);
    halt = 1'b1;
    step();
    clear_logs();
    out_ready = 1'b1;
    repeat (4) step();
    chk("t4_no_reads", grant_log.size(), 0);
    chk("t4_drained", xfer_data.size(), 2);
    chk("t4_halted", int'(halted), 1);
    halt = 1'b0;
    clear_logs();
    step();
    chk("t4_still_halted_cycle", grant_log.size(), 0);
    step();
    chk("t4_resume", grant_log.size(), 1);

    // Sticky error and reset mid-stream
    clear_fifos();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      fq[2].push_back(16'h0200 + 16'(i)); fq[6].push_back(16'h0600 + 16'(i));
    end
    repeat (3) step();
    chk("t5_error_clear", int'(error), 0);
    fifo_error = 1'b1;
    step();
    fifo_error = 1'b0;
    repeat (3) step();
    chk("t5_error_sticky", int'(error), 1);
    out_ready = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    #1;
    chk("t5_rst_valid", int'(out_valid), 0);
    chk("t5_rst_read", int'(read), 0);
    @(negedge clock);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    chk("t5_error_cleared", int'(error), 0);
    clear_logs();
    fq[0].push_back(16'h0042);
    step();
    chk("t5_first_reads", grant_log.size(), 1);
    if (grant_log.size() > 0) chk("t5_first_grant", grant_log[0], 0);
    repeat (3) step();

    // Context 0 deep, context 3 shallow
    clear_fifos();
    do_reset();
    for (int i = 0; i < 3; i++) fq[0].push_back(16'h0000 + 16'(i));
    fq[3].push_back(16'h0300); fq[3].push_back(16'h0301);
    repeat (8) step();
    chk("t6_reads", grant_log.size(), 5);
    for (int i = 0; i < 5; i++) if (i < grant_log.size()) chk("t6_grant", grant_log[i], e6[i]);

    // Randomised traffic
    clear_fifos();
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 3) == 0 && fq[c].size() < 6) begin
          fq[c].push_back(16'((c << 12) | (seq & 12'hFFF)));
          seq++;
        end
      end
      if ($urandom_range(0, 15) == 0) ctx_mask = N'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) halt = ~halt;
      fifo_error = ($urandom_range(0, 1499) == 0);
      reset      = ($urandom_range(0, 599) == 0);
      step();
    end
    reset = 1'b0;
    fifo_error = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
